// File: rtl/motor_pwm_pkg.sv
// Shared types and constants for the two-channel H-bridge PWM stage.
// Optional duty ramping is enabled by defining MOTOR_PWM_RAMP_EN.
package motor_pwm_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DEAD  = 2'd1,
    BRAKE = 2'd2
  } chan_state_t;

  // Field positions inside the latched 32-bit command word
  localparam int DUTY_A_LSB  = 0;
  localparam int DIR_A_BIT   = 8;
  localparam int BRAKE_A_BIT = 9;
  localparam int DUTY_B_LSB  = 16;
  localparam int DIR_B_BIT   = 24;
  localparam int BRAKE_B_BIT = 25;
  localparam int ENABLE_BIT  = 31;

  localparam logic [7:0] RAMP_STEP = 8'd8;

  // Move cur toward tgt by at most RAMP_STEP.
  function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
    if (tgt > cur)
      return ((tgt - cur) > RAMP_STEP) ? cur + RAMP_STEP : tgt;
    else
      return ((cur - tgt) > RAMP_STEP) ? cur - RAMP_STEP : tgt;
  endfunction

endpackage

// File: rtl/motor_pwm_chan.sv
// One H-bridge channel: RUN/DEAD/BRAKE sequencing at period boundaries, pins registered one cycle after the counter.
// No backpressure; optional duty ramp selected by MOTOR_PWM_RAMP_EN.
module motor_pwm_chan
  import motor_pwm_pkg::*;
#(
  parameter int DEAD_PERIODS = 2
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       bnd,
  input  logic [7:0] cnt,
  input  logic [7:0] duty_n,
  input  logic       dir_n,
  input  logic       brake_n,
  output logic       in1,
  output logic       in2,
  output logic       dead
);

`ifdef MOTOR_PWM_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif
  localparam logic [3:0] DEAD_LAST = 4'(DEAD_PERIODS - 1);

  chan_state_t state, state_nx;
  logic        dir_q, dir_nx;
  logic [7:0]  duty_q, duty_nx;
  logic [3:0]  dead_q, dead_nx;
  logic        pwm, in1_d, in2_d;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state  <= RUN;
      dir_q  <= 1'b0;
      duty_q <= 8'd0;
      dead_q <= 4'd0;
      in1    <= 1'b0;
      in2    <= 1'b0;
    end else begin
      state  <= state_nx;
      dir_q  <= dir_nx;
      duty_q <= duty_nx;
      dead_q <= dead_nx;
      in1    <= in1_d;
      in2    <= in2_d;
    end
  end

  always_comb begin
    state_nx = state;
    dir_nx   = dir_q;
    duty_nx  = duty_q;
    dead_nx  = dead_q;
    if (bnd) begin
`ifdef MOTOR_PWM_RAMP_EN
      // A pending reversal drains the duty to zero before the dead-time starts.
      duty_nx = (state == RUN) ? slew(duty_q, (dir_n != dir_q) ? 8'd0 : duty_n) : 8'd0;
`else
      duty_nx = duty_n;
`endif
      case (state)
        RUN: begin
          if (brake_n)
            state_nx = BRAKE;
          else if ((dir_n != dir_q) && (!RAMP_ON || duty_q == 8'd0)) begin
            state_nx = DEAD;
            dead_nx  = 4'd0;
          end
        end
        DEAD: begin
          if (brake_n)
            state_nx = BRAKE;
          else if (dead_q == DEAD_LAST) begin
            state_nx = RUN;
            dir_nx   = dir_n;
          end else
            dead_nx = dead_q + 4'd1;
        end
        BRAKE: begin
          if (!brake_n) begin
            state_nx = RUN;
            dir_nx   = dir_n;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  assign pwm = (cnt < duty_q);

  always_comb begin
    in1_d = 1'b0;
    in2_d = 1'b0;
    case (state)
      RUN: begin
        in1_d = pwm & ~dir_q;
        in2_d = pwm & dir_q;
      end
      BRAKE: begin
        in1_d = 1'b1;
        in2_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign dead = (state == DEAD);

endmodule

// File: rtl/motor_pwm_stage.sv
// Two-motor PWM stage: prescaler, shared 8-bit PWM counter, command shadow and two bridge channels.
// Pins lag the counter by one cycle; no backpressure. Define MOTOR_PWM_RAMP_EN for duty slewing.
module motor_pwm_stage
  import motor_pwm_pkg::*;
#(
  parameter int CLK_DIV      = 50,
  parameter int PWM_MAX      = 255,
  parameter int DEAD_PERIODS = 2
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [31:0] cmd_data,
  input  logic        cmd_valid,
  output logic        a_in1,
  output logic        a_in2,
  output logic        b_in1,
  output logic        b_in2,
  output logic        period_start,
  output logic        busy
);

  localparam logic [15:0] DIV_TC = 16'(CLK_DIV - 1);
  localparam logic [7:0]  CNT_TC = 8'(PWM_MAX);

  logic [15:0] presc_q;
  logic [7:0]  cnt_q;
  logic [31:0] shadow_q, word_n;
  logic        tick, bnd, en;
  logic        a1_q, a2_q, b1_q, b2_q, dead_a, dead_b;
  logic        unused_word;

  assign tick = (presc_q == DIV_TC);
  assign bnd  = tick && (cnt_q == CNT_TC);
  // A write landing on the boundary cycle is the word that takes effect.
  assign word_n = cmd_valid ? cmd_data : shadow_q;
  assign unused_word = ^{word_n[15:10], word_n[31:26]};

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      presc_q      <= 16'd0;
      cnt_q        <= 8'd0;
      shadow_q     <= 32'd0;
      period_start <= 1'b0;
    end else begin
      presc_q      <= tick ? 16'd0 : presc_q + 16'd1;
      if (tick)
        cnt_q <= (cnt_q == CNT_TC) ? 8'd0 : cnt_q + 8'd1;
      if (cmd_valid)
        shadow_q <= cmd_data;
      period_start <= bnd;
    end
  end

  motor_pwm_chan #(.DEAD_PERIODS(DEAD_PERIODS)) u_chan_a (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .bnd     (bnd),
    .cnt     (cnt_q),
    .duty_n  (word_n[DUTY_A_LSB +: 8]),
    .dir_n   (word_n[DIR_A_BIT]),
    .brake_n (word_n[BRAKE_A_BIT]),
    .in1     (a1_q),
    .in2     (a2_q),
    .dead    (dead_a)
  );

  motor_pwm_chan #(.DEAD_PERIODS(DEAD_PERIODS)) u_chan_b (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .bnd     (bnd),
    .cnt     (cnt_q),
    .duty_n  (word_n[DUTY_B_LSB +: 8]),
    .dir_n   (word_n[DIR_B_BIT]),
    .brake_n (word_n[BRAKE_B_BIT]),
    .in1     (b1_q),
    .in2     (b2_q),
    .dead    (dead_b)
  );

  // Enable follows the most recent write, not the period boundary.
  assign en    = shadow_q[ENABLE_BIT];
  assign a_in1 = a1_q & en;
  assign a_in2 = a2_q & en;
  assign b_in1 = b1_q & en;
  assign b_in2 = b2_q & en;
  assign busy  = dead_a | dead_b;

endmodule

// File: tb/tb_motor_pwm_stage.sv
// Directed bench for motor_pwm_stage with a cycle-index reference model checked every cycle.
`timescale 1ns/1ps
module tb_motor_pwm_stage;

  localparam int CLK_DIV      = 3;
  localparam int DEAD_PERIODS = 2;
  localparam int PER          = 256 * CLK_DIV;

  logic        tb_ACLK = 1'b0;
  logic        ARESET  = 1'b1;
  logic [31:0] cmd_data = 32'd0;
  logic        cmd_valid = 1'b0;
  logic        a_in1, a_in2, b_in1, b_in2, period_start, busy;

  always #5 tb_ACLK = ~tb_ACLK;

  motor_pwm_stage #(.CLK_DIV(CLK_DIV), .PWM_MAX(255), .DEAD_PERIODS(DEAD_PERIODS)) dut (
    .ACLK         (tb_ACLK),
    .ARESET       (ARESET),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .a_in1        (a_in1),
    .a_in2        (a_in2),
    .b_in1        (b_in1),
    .b_in2        (b_in2),
    .period_start (period_start),
    .busy         (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: time is a plain cycle index since reset; mode 0=run 1=dead 2=brake.
  bit          m_ok = 1'b0;
  int          m_k;
  logic [31:0] m_shadow;
  int          m_mode [2];
  int          m_dir  [2];
  int          m_duty [2];
  int          m_left [2];
  logic [1:0]  m_pins [2];
  logic        m_ps;
  int          m_cnt_prev;
  bit          m_bnd;
  logic [31:0] m_w;

  function automatic logic [1:0] pins_of(input int mode, input int dir, input int duty, input int cnt);
    logic pwm;
    pwm = (cnt < duty);
    case (mode)
      0:       return (dir != 0) ? {1'b0, pwm} : {pwm, 1'b0};
      2:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic step(input int c, input logic [7:0] d, input logic dr, input logic br);
    if (br)
      m_mode[c] = 2;
    else if (m_mode[c] == 2) begin
      m_mode[c] = 0;
      m_dir[c]  = int'(dr);
    end else if (m_mode[c] == 1) begin
      m_left[c] = m_left[c] - 1;
      if (m_left[c] == 0) begin
        m_mode[c] = 0;
        m_dir[c]  = int'(dr);
      end
    end else if (int'(dr) != m_dir[c]) begin
      m_mode[c] = 1;
      m_left[c] = DEAD_PERIODS;
    end
    m_duty[c] = int'(d);
  endtask

  always @(posedge tb_ACLK) begin
    if (ARESET) begin
      m_ok = 1'b1;
      m_k = 0;
      m_shadow = 32'd0;
      m_ps = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_mode[c] = 0; m_dir[c] = 0; m_duty[c] = 0; m_left[c] = 0; m_pins[c] = 2'b00;
      end
    end else if (m_ok) begin
      m_cnt_prev = (m_k / CLK_DIV) % 256;
      m_bnd = (((m_k + 1) % PER) == 0);
      for (int c = 0; c < 2; c++)
        m_pins[c] = pins_of(m_mode[c], m_dir[c], m_duty[c], m_cnt_prev);
      if (m_bnd) begin
        m_w = cmd_valid ? cmd_data : m_shadow;
        step(0, m_w[7:0], m_w[8], m_w[9]);
        step(1, m_w[23:16], m_w[24], m_w[25]);
      end
      if (cmd_valid) m_shadow = cmd_data;
      m_ps = m_bnd;
      m_k = m_k + 1;
    end
  end

  logic [5:0] exp_v, got_v;
  always @(negedge tb_ACLK) begin
    if (m_ok) begin
      exp_v = {m_pins[0] & {2{m_shadow[31]}}, m_pins[1] & {2{m_shadow[31]}}, m_ps,
               (m_mode[0] == 1 || m_mode[1] == 1)};
      got_v = {a_in1, a_in2, b_in1, b_in2, period_start, busy};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        if (n_bad <= 20)
          $display("FAIL cycle k=%0d {a1,a2,b1,b2,ps,busy} got=%b exp=%b", m_k, got_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  int c_a1, c_a2, c_b1, c_b2, c_ps, c_busy;
  task automatic measure(input int n);
    c_a1 = 0; c_a2 = 0; c_b1 = 0; c_b2 = 0; c_ps = 0; c_busy = 0;
    repeat (n) begin
      @(negedge tb_ACLK);
      c_a1 += int'(a_in1); c_a2 += int'(a_in2);
      c_b1 += int'(b_in1); c_b2 += int'(b_in2);
      c_ps += int'(period_start); c_busy += int'(busy);
    end
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      @(negedge tb_ACLK);
      n++;
    end while (period_start !== 1'b1 && n < 2 * PER);
    if (period_start !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_ps timeout got=%0d cycles exp<=%0d", n, PER);
    end
  endtask

  task automatic send(input logic [31:0] w);
    cmd_data  = w;
    cmd_valid = 1'b1;
    @(negedge tb_ACLK);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    ARESET = 1'b1;
    repeat (3) @(negedge tb_ACLK);
    ARESET = 1'b0;
    check("reset_outputs", int'({a_in1, a_in2, b_in1, b_in2, period_start, busy}), 0);
    wait_ps(n); check("first_ps_delay", n, 768);
    wait_ps(n); check("ps_interval", n, 768);

    // Forward duty 64 then 255 on channel A
    send(32'h8000_0040); wait_ps(n); measure(PER);
    check("fwd64_a1", c_a1, 192); check("fwd64_a2", c_a2, 0);
    check("fwd64_b", c_b1 + c_b2, 0); check("fwd64_ps", c_ps, 1);
    send(32'h8000_00FF); wait_ps(n); measure(PER);
    check("fwd255_a1", c_a1, 765);

    // Reversal with dead-time
    send(32'h8000_0080); wait_ps(n); measure(PER);
    check("fwd128_a1", c_a1, 384);
    send(32'h8000_0180); wait_ps(n);
    measure(PER); check("dead1_pins", c_a1 + c_a2, 0); check("dead1_busy", c_busy, 768);
    measure(PER); check("dead2_pins", c_a1 + c_a2, 0); check("dead2_busy", c_busy, 767);
    measure(PER); check("rev_a1", c_a1, 0); check("rev_a2", c_a2, 384); check("rev_busy", c_busy, 0);

    // Brake pre-empts dead-time, release skips dead-time
    send(32'h8000_0080); wait_ps(n);
    check("busy_in_dead", int'(busy), 1);
    send(32'h8000_0380); wait_ps(n); measure(PER);
    check("brake_a1", c_a1, 768); check("brake_a2", c_a2, 768); check("brake_busy", c_busy, 0);
    send(32'h8000_0080); wait_ps(n); measure(PER);
    check("unbrake_a1", c_a1, 384); check("unbrake_a2", c_a2, 0); check("unbrake_busy", c_busy, 0);

    // Enable mask, then a write on the exact wrap cycle
    send(32'h0001_0101);
    check("mask_immediate", int'({a_in1, a_in2, b_in1, b_in2}), 0);
    wait_ps(n); measure(PER);
    check("masked_pins", c_a1 + c_a2 + c_b1 + c_b2, 0); check("masked_ps", c_ps, 1);
    repeat (PER - 1) @(negedge tb_ACLK);
    send(32'h8040_0080);
    check("wrap_aligned", int'(period_start), 1);
    measure(PER);
    check("wrapwr_b1", c_b1, 192); check("wrapwr_a1", c_a1, 384); check("wrapwr_busy", c_busy, 0);

    // Reset in the middle of a reverse high phase on B
    send(32'h8180_0080);
    wait_ps(n); wait_ps(n); wait_ps(n);
    repeat (100) @(negedge tb_ACLK);
    check("b_rev_high", int'(b_in2), 1);
    ARESET = 1'b1;
    @(negedge tb_ACLK);
    ARESET = 1'b0;
    check("pins_after_reset", int'({a_in1, a_in2, b_in1, b_in2, period_start, busy}), 0);
    wait_ps(n); check("ps_after_reset", n, 768);
    send(32'h8000_0040); wait_ps(n); measure(PER);
    check("post_reset_a1", c_a1, 192); check("post_reset_b", c_b1 + c_b2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
